// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle hazard unit: FSM states, unit indices
// and the priority helper used to pick the served unit.
package core_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

    localparam int unsigned UNIT_SHORT_FPU = 0;
    localparam int unsigned UNIT_LONG_FPU  = 1;
    localparam int unsigned UNIT_CACHE     = 2;
    localparam int unsigned UNIT_INPUT     = 3;

    localparam int MAX_UNITS = 32;

    // Index of the lowest set bit; 0 for an all-zero vector.
    function automatic int unsigned lowest_set_index(input logic [MAX_UNITS-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_UNITS - 1; i >= 0; i--) begin
            if (vec[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mc_hazard_unit_if.sv
// Handshake bundle between the hazard unit (master) and its execution units (slave).
interface mc_hazard_unit_if #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned DATA_W    = 32
);
    logic [NUM_UNITS-1:0]        unit_en;
    logic [NUM_UNITS-1:0]        unit_valid;
    logic [NUM_UNITS*DATA_W-1:0] unit_result;

    modport master (output unit_en, input unit_valid, input unit_result);
    modport slave  (input unit_en, output unit_valid, output unit_result);
endinterface

// File: rtl/mc_timeout_ctr.sv
// Clearable saturating WAIT-cycle counter; hit flags the last allowed cycle.
module mc_timeout_ctr #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TO_W    = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);
    localparam logic [TO_W-1:0] CNT_MAX = '1;
    localparam logic [TO_W-1:0] HIT_VAL = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (TIMEOUT == 0 || clr) begin
            count <= '0;
        end else if (en && count != CNT_MAX) begin
            count <= count + TO_W'(1);
        end
    end

    assign hit = (TIMEOUT != 0) && (count == HIT_VAL);

endmodule

// File: rtl/mc_hazard_unit.sv
// Arbitrates variable-latency exec-stage units: issues one enable pulse, stalls
// until the selected unit's valid (or a timeout) and holds the result across io_stall.
module mc_hazard_unit
    import core_pkg::*;
#(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned TO_W      = 11,
    localparam int unsigned EU_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pc_src_e,
    input  logic                 io_stall,
    input  logic [NUM_UNITS-1:0] unit_req_e,
    mc_hazard_unit_if.master     units,
    output logic [DATA_W-1:0]    result_out,
    output logic                 result_ok,
    output logic                 stall,
    output logic                 flush,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 proto_err,
    output logic [EU_W-1:0]      err_unit
);
    state_e                state_q;
    logic [EU_W-1:0]       sel_q;
    logic [DATA_W-1:0]     result_q;
    logic [NUM_UNITS-1:0]  unit_en_q;

    logic                  req_any, multi_hot, valid_sel, ctr_hit;
    logic                  stall_raw, ok_raw;
    logic [EU_W-1:0]       req_sel;
    logic [DATA_W-1:0]     res_sel;

    assign req_any   = |unit_req_e;
    assign multi_hot = (unit_req_e & (unit_req_e - NUM_UNITS'(1))) != '0;
    assign req_sel   = EU_W'(lowest_set_index(MAX_UNITS'(unit_req_e)));
    assign valid_sel = units.unit_valid[sel_q];
    assign res_sel   = units.unit_result[32'(sel_q) * DATA_W +: DATA_W];

    mc_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout_ctr (
        .clk (clk),
        .rst (rst),
        .clr (state_q == IDLE),
        .en  (state_q == WAIT && !valid_sel),
        .hit (ctr_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            result_q    <= '0;
            unit_en_q   <= '0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
            err_unit    <= '0;
        end else begin
            unit_en_q <= '0;
            if (multi_hot) proto_err <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (req_any) begin
                        sel_q     <= req_sel;
                        unit_en_q <= NUM_UNITS'(1) << req_sel;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (valid_sel) begin
                        result_q <= res_sel;
                        state_q  <= io_stall ? HOLD : IDLE;
                    end else if (ctr_hit) begin
                        timeout_err <= 1'b1;
                        if (!timeout_err) err_unit <= sel_q;
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    if (!io_stall) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A timeout releases the pipeline with a zero result rather than hanging it.
    always_comb begin
        stall_raw  = 1'b0;
        ok_raw     = 1'b0;
        result_out = '0;
        unique case (state_q)
            IDLE: stall_raw = req_any;
            WAIT: begin
                if (valid_sel) begin
                    ok_raw     = 1'b1;
                    result_out = res_sel;
                end else if (ctr_hit) begin
                    ok_raw = 1'b1;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            HOLD: begin
                ok_raw     = 1'b1;
                result_out = result_q;
            end
            default: ;
        endcase
    end

    assign units.unit_en = unit_en_q;
    assign stall         = stall_raw & ~rst;
    assign result_ok     = ok_raw & ~rst;
    assign busy          = (state_q != IDLE) & ~rst;
    assign flush         = pc_src_e & ~stall_raw & ~rst;

endmodule

// File: tb/tb_mc_hazard_unit.sv
// Directed bench for mc_hazard_unit: a default instance plus a TIMEOUT=8
// instance share all stimulus.
module tb_mc_hazard_unit;
    import core_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         pc_src_e;
    logic         io_stall;
    logic [3:0]   req;
    logic [3:0]   valid;
    logic [127:0] result;

    logic [31:0] res_a, res_b;
    logic        ok_a, stall_a, flush_a, busy_a, to_a, pe_a;
    logic        ok_b, stall_b, flush_b, busy_b, to_b, pe_b;
    logic [1:0]  eu_a, eu_b;

    int total = 0;
    int bad   = 0;

    mc_hazard_unit_if #(.NUM_UNITS(4), .DATA_W(32)) bus_a ();
    mc_hazard_unit_if #(.NUM_UNITS(4), .DATA_W(32)) bus_b ();

    assign bus_a.unit_valid  = valid;
    assign bus_a.unit_result = result;
    assign bus_b.unit_valid  = valid;
    assign bus_b.unit_result = result;

    mc_hazard_unit #(.NUM_UNITS(4), .DATA_W(32), .TIMEOUT(1024), .TO_W(11)) dut_a (
        .clk (clk), .rst (rst), .pc_src_e (pc_src_e), .io_stall (io_stall),
        .unit_req_e (req), .units (bus_a.master), .result_out (res_a), .result_ok (ok_a),
        .stall (stall_a), .flush (flush_a), .busy (busy_a), .timeout_err (to_a),
        .proto_err (pe_a), .err_unit (eu_a)
    );

    mc_hazard_unit #(.NUM_UNITS(4), .DATA_W(32), .TIMEOUT(8), .TO_W(4)) dut_b (
        .clk (clk), .rst (rst), .pc_src_e (pc_src_e), .io_stall (io_stall),
        .unit_req_e (req), .units (bus_b.master), .result_out (res_b), .result_ok (ok_b),
        .stall (stall_b), .flush (flush_b), .busy (busy_b), .timeout_err (to_b),
        .proto_err (pe_b), .err_unit (eu_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 2 time units after the edge, outputs checked 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; pc_src_e = 1'b0; io_stall = 1'b0;
        req = '0; valid = '0; result = '0;

        // Reset state, outputs gated while rst is high
        cyc();
        req = 4'b0001;
        #1;
        chk("rst_stall", stall_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_en", bus_a.unit_en, 4'b0000);
        chk("rst_ok", ok_a, 1'b0);
        chk("rst_to", to_a, 1'b0);
        chk("rst_pe", pe_a, 1'b0);
        chk("rst_eu", eu_a, 2'd0);
        req = '0;
        cyc();
        rst = 1'b0;

        // Reset mid-WAIT
        cyc();
        req = 4'b0010;
        #1;
        chk("mw_idle_stall", stall_a, 1'b1);
        chk("mw_idle_en", bus_a.unit_en, 4'b0000);
        cyc(); #1;
        chk("mw_en", bus_a.unit_en, 4'b0010);
        chk("mw_busy", busy_a, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("mw_wait_stall", stall_a, 1'b1);
        end
        chk("mw_en_once", bus_a.unit_en, 4'b0000);
        rst = 1'b1;
        #1;
        chk("mw_rst_stall", stall_a, 1'b0);
        chk("mw_rst_en", bus_a.unit_en, 4'b0000);
        chk("mw_rst_busy", busy_a, 1'b0);
        req = '0;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            chk("mw_post_en", bus_a.unit_en, 4'b0000);
            chk("mw_post_busy", busy_a, 1'b0);
        end

        // Zero-latency unit
        cyc();
        req = 4'b0001;
        #1;
        chk("zl_stall1", stall_a, 1'b1);
        chk("zl_ok1", ok_a, 1'b0);
        cyc();
        valid = 4'b0001;
        result[31:0] = 32'hDEADBEEF;
        #1;
        chk("zl_en", bus_a.unit_en, 4'b0001);
        chk("zl_stall2", stall_a, 1'b0);
        chk("zl_ok2", ok_a, 1'b1);
        chk("zl_res", res_a, 32'hDEADBEEF);
        cyc();
        req = '0; valid = '0;
        #1;
        chk("zl_en_off", bus_a.unit_en, 4'b0000);
        chk("zl_busy", busy_a, 1'b0);
        chk("zl_ok3", ok_a, 1'b0);

        // Timeout on the TIMEOUT=8 instance
        cyc();
        req = 4'b0100;
        #1;
        chk("to_idle_stall", stall_b, 1'b1);
        cyc(); #1;
        chk("to_en", bus_b.unit_en, 4'b0100);
        chk("to_w1_stall", stall_b, 1'b1);
        for (int k = 2; k <= 8; k++) begin
            cyc(); #1;
            chk("to_stall", stall_b, (k < 8) ? 1'b1 : 1'b0);
        end
        chk("to_ok", ok_b, 1'b1);
        chk("to_res", res_b, 32'h0);
        req = '0;
        cyc(); #1;
        chk("to_err", to_b, 1'b1);
        chk("to_unit", eu_b, 2'd2);
        chk("to_busy", busy_b, 1'b0);
        chk("to_a_clear", to_a, 1'b0);
        valid = 4'b0100;
        result[95:64] = 32'h12345678;
        #1;
        chk("to_late_ok", ok_b, 1'b0);
        chk("to_late_stall", stall_b, 1'b0);
        cyc();
        valid = '0;
        #1;
        chk("to_late_busy", busy_b, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // Long latency followed by io_stall hold
        cyc();
        req = 4'b0010;
        #1;
        chk("ll_idle_stall", stall_a, 1'b1);
        cyc(); #1;
        chk("ll_en", bus_a.unit_en, 4'b0010);
        for (int i = 2; i <= 10; i++) begin
            cyc(); #1;
            chk("ll_wait_stall", stall_a, 1'b1);
        end
        cyc();
        valid = 4'b0010;
        result[63:32] = 32'h3F800000;
        io_stall = 1'b1;
        #1;
        chk("ll_done_stall", stall_a, 1'b0);
        chk("ll_done_ok", ok_a, 1'b1);
        chk("ll_done_res", res_a, 32'h3F800000);
        for (int h = 1; h <= 3; h++) begin
            cyc();
            valid = '0;
            result[63:32] = 32'h0;
            if (h == 3) io_stall = 1'b0;
            #1;
            chk("ll_hold_res", res_a, 32'h3F800000);
            chk("ll_hold_ok", ok_a, 1'b1);
            chk("ll_hold_stall", stall_a, 1'b0);
            chk("ll_hold_en", bus_a.unit_en, 4'b0000);
            chk("ll_hold_busy", busy_a, 1'b1);
        end
        cyc();
        req = '0;
        #1;
        chk("ll_exit_busy", busy_a, 1'b0);
        chk("ll_exit_en", bus_a.unit_en, 4'b0000);

        // Multi-hot request
        cyc();
        req = 4'b1010;
        #1;
        chk("mh_idle_pe", pe_a, 1'b0);
        chk("mh_idle_stall", stall_a, 1'b1);
        cyc(); #1;
        chk("mh_en", bus_a.unit_en, 4'b0010);
        chk("mh_pe", pe_a, 1'b1);
        valid = 4'b1000;
        result[127:96] = 32'hAAAA5555;
        #1;
        chk("mh_other_stall", stall_a, 1'b1);
        chk("mh_other_ok", ok_a, 1'b0);
        cyc();
        valid = 4'b0010;
        result[63:32] = 32'h11111111;
        #1;
        chk("mh_en_off", bus_a.unit_en, 4'b0000);
        chk("mh_ok", ok_a, 1'b1);
        chk("mh_res", res_a, 32'h11111111);
        cyc();
        req = '0; valid = '0;
        #1;
        chk("mh_busy", busy_a, 1'b0);

        // Flush deferral while stalled, then direct pass-through
        cyc();
        req = 4'b0001;
        pc_src_e = 1'b1;
        #1;
        chk("fl_stalled", flush_a, 1'b0);
        cyc();
        valid = 4'b0001;
        result[31:0] = 32'h00000042;
        #1;
        chk("fl_release", flush_a, 1'b1);
        cyc();
        req = '0; valid = '0;
        #1;
        chk("fl_direct1", flush_a, 1'b1);
        pc_src_e = 1'b0;
        #1;
        chk("fl_direct0", flush_a, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_hazard_unit.md
Name: mc_hazard_unit

Overview:
- Parametrised successor to the core's hazard unit. Arbitrates N variable-latency execution-stage units (short FPU, long FPU, cache, input port, ...) through one FSM.
- Per unit: one-cycle enable pulse, valid wait, and result capture that survives io_stall.
- Adds a per-operation timeout watchdog and protocol-error detection.
- Sits beside the pipeline registers. Drives stall/flush and the exec-stage result mux.

Parameters:
NUM_UNITS, 4, number of variable-latency units (>=1)
DATA_W, 32, result width per unit
TIMEOUT, 1024, max WAIT cycles before abort; 0 disables the watchdog
TO_W, 11, timeout counter width; must satisfy 2**TO_W > TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
pc_src_e  in  1  exec-stage branch/jump taken
io_stall  in  1  external I/O freeze of the whole pipeline
unit_req_e  in  NUM_UNITS  exec-stage instruction needs unit k; one-hot or zero
unit_valid  in  NUM_UNITS  unit k result ready; one-cycle pulse
unit_result  in  NUM_UNITS*DATA_W  unit k result in slice [k*DATA_W +: DATA_W]
unit_en  out  NUM_UNITS  one-cycle start pulse to unit k
result_out  out  DATA_W  selected unit result for the exec stage
result_ok  out  1  result_out is valid this cycle
stall  out  1  freeze fetch..exec
flush  out  1  kill younger stages
busy  out  1  FSM not IDLE
timeout_err  out  1  sticky: an operation timed out
proto_err  out  1  sticky: multi-hot unit_req_e seen
err_unit  out  $clog2(NUM_UNITS) (min 1)  index of the first timed-out unit

Behaviour:
- Reset (async, any state): FSM=IDLE; sel, counter, result_q, unit_en, timeout_err, proto_err, err_unit all 0. stall, flush, busy, result_ok are 0 while rst is high.
- sel = lowest set index of unit_req_e. If more than one bit is set, proto_err is set (sticky) and sel is still served.
- IDLE:
  - unit_req_e != 0: stall=1; register sel; unit_en[sel] goes high next cycle; go to WAIT; clear counter.
  - unit_req_e == 0: stall=0.
  - io_stall does not block issue.
- WAIT:
  - unit_en[sel]=1 only in the first WAIT cycle. unit_en is 0 everywhere else.
  - unit_valid[sel] is accepted in any WAIT cycle, including the enable cycle, so zero-latency units are legal.
  - unit_valid[sel]=1: stall=0, result_ok=1, result_out=unit_result[sel] combinationally, result_q<=that value. Next state is IDLE if io_stall=0, else HOLD.
  - unit_valid[sel]=0: stall=1; counter+1.
  - unit_valid for k != sel is ignored.
  - TIMEOUT!=0 and counter==TIMEOUT-1 without valid: set timeout_err. If it was previously clear, err_unit<=sel. Go to IDLE releasing the stall (stall=0, result_ok=1, result_out=0) so the pipeline cannot hang.
- HOLD (pipeline frozen by io_stall after completion):
  - stall=0, result_ok=1, result_out=result_q.
  - No re-issue even though unit_req_e is unchanged.
  - Exit to IDLE in the first cycle io_stall=0.
- Minimum issue-to-advance latency is 2 cycles (IDLE stall cycle + enable cycle with same-cycle valid).
- flush = pc_src_e & ~stall. While stall=1, flush is deferred, not dropped; the branch instruction remains in exec.
- busy = (state != IDLE).
- Counter saturates and never wraps. With TIMEOUT=0 it is held at 0.
- Results from other units outside WAIT are ignored. A late valid after a timeout is discarded.

Decomposition:
- Shared package core_pkg holds:
  - FSM state enum: IDLE, WAIT, HOLD.
  - Unit index constants: UNIT_SHORT_FPU=0, UNIT_LONG_FPU=1, UNIT_CACHE=2, UNIT_INPUT=3.
  - Function lowest_set_index.
- One sub-module, mc_timeout_ctr: clear/enable/saturating counter with a hit output, parametrised by TIMEOUT and TO_W.
- The result mux stays inline.

Test Plan:
- Reset mid-WAIT: req=4'b0010, valid withheld 5 cycles, assert rst → stall=0, unit_en=0, busy=0 immediately; no en pulse after release.
- Zero-latency: req=4'b0001, valid[0]=1 with result 0xDEADBEEF in the enable cycle → stall high for exactly 1 cycle; result_ok=1, result_out=0xDEADBEEF in cycle 2; unit_en[0] pulsed once.
- Long latency with io_stall: req=4'b0010, valid[1] after 10 cycles with 0x3F800000, io_stall=1 for 3 cycles from completion → HOLD; result_out stays 0x3F800000 for 3 cycles; no second unit_en[1]; IDLE after io_stall drops.
- Timeout: TIMEOUT=8, req=4'b0100, valid never asserted → stall drops after the 8th WAIT cycle; timeout_err=1, err_unit=2; a later valid[2] is ignored.
- Multi-hot: req=4'b1010 → proto_err=1; unit_en[1] pulses; unit_en[3] stays 0; valid[3] during WAIT is ignored.
- Flush deferral: pc_src_e=1 while stall=1 → flush=0; flush=1 in the cycle stall falls; with req=0, flush follows pc_src_e directly.
